// File: rtl/demux_4out_nbit_reg.sv
// Registered 1-to-4 N-bit demultiplexer with a one-entry holding register per channel.
// The destination comes from {s1,s0} or from a round-robin pointer.
module demux_4out_nbit_reg #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] x,
    input  logic         x_valid,
    output logic         x_ready,
    input  logic         s1,
    input  logic         s0,
    input  logic         rr_mode,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [N-1:0] C,
    output logic [N-1:0] D,
    output logic         a_valid,
    output logic         b_valid,
    output logic         c_valid,
    output logic         d_valid,
    input  logic         a_ready,
    input  logic         b_ready,
    input  logic         c_ready,
    input  logic         d_ready,
    output logic [1:0]   rr_ptr,
    output logic         idle
);

    logic [3:0][N-1:0] data_q, data_d;
    logic [3:0]        valid_q, valid_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [3:0]        ready_vec;
    logic [1:0]        dest;
    logic              accept;

    assign ready_vec = {d_ready, c_ready, b_ready, a_ready};

    always_comb begin
        dest    = rr_mode ? rr_ptr_q : {s1, s0};
        // A draining destination accepts in the same cycle, so no bubble.
        x_ready = !valid_q[dest] || ready_vec[dest];
        accept  = x_valid && x_ready;
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        for (int k = 0; k < 4; k++) begin
            if (accept && (dest == 2'(k))) begin
                data_d[k]  = x;
                valid_d[k] = 1'b1;
            end else if (valid_q[k] && ready_vec[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && rr_mode) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            valid_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        A       = data_q[0];
        B       = data_q[1];
        C       = data_q[2];
        D       = data_q[3];
        a_valid = valid_q[0];
        b_valid = valid_q[1];
        c_valid = valid_q[2];
        d_valid = valid_q[3];
        rr_ptr  = rr_ptr_q;
        idle    = ~|valid_q;
    end

endmodule

// File: doc/demux_4out_nbit_reg.md
Name: demux_4out_nbit_reg

Overview:
- Registered 1-to-4 N-bit demultiplexer: the distributing counterpart of the team's 4-input N-bit selector.
- Accepts one N-bit input word per valid/ready handshake.
- Steers each word to output channel A, B, C or D. The channel is chosen by the select pair {s1,s0} or by an internal round-robin pointer.
- Each channel has a one-entry output holding register with its own valid/ready handshake. This lets the ALU datapath fan results out to up to four consumers that stall independently.

Parameters:
- N, 4, data width in bits (N >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- x  input  N  input data word
- x_valid  input  1  input word present
- x_ready  output  1  block can accept x this cycle
- s1  input  1  select MSB (used when rr_mode=0)
- s0  input  1  select LSB (used when rr_mode=0)
- rr_mode  input  1  0 = select-driven steering, 1 = round-robin steering
- A, B, C, D  output  N each  registered channel data (channel 0..3)
- a_valid, b_valid, c_valid, d_valid  output  1 each  channel holds a word
- a_ready, b_ready, c_ready, d_ready  input  1 each  consumer takes the word
- rr_ptr  output  2  current round-robin pointer
- idle  output  1  all four channel valids are low

Behaviour:
- Reset (rst_n low, asynchronous; takes effect immediately, independent of clk):
  - A, B, C, D = 0.
  - All channel valids = 0.
  - rr_ptr = 0.
  - idle = 1.
  - Asserting reset mid-transfer discards all held words; no output handshake completes.
- Destination (combinational, evaluated every cycle):
  - dest = rr_ptr when rr_mode=1, else {s1,s0}.
  - Encoding: 0 = A, 1 = B, 2 = C, 3 = D.
- x_ready:
  - x_ready = !valid[dest] || ready[dest].
  - A full channel that is draining this cycle accepts a new word in the same cycle (pass-through ready path; no bubble).
  - x_ready does not depend on x_valid.
- Accept: when x_valid && x_ready, at the rising edge:
  - x is written into channel dest.
  - valid[dest] is set.
  - Latency is 1 cycle: the word is visible on the channel output the cycle after acceptance.
- Channel k update at each edge, in priority order:
  - Load this cycle: data_k <= x, valid_k <= 1. This applies even if ready_k drains the old word in the same cycle.
  - Else if valid_k && ready_k: valid_k <= 0. Data_k keeps its last value; it is don't-care while valid_k=0.
  - Else: data_k and valid_k hold.
- Output stability: while valid_k=1 and ready_k=0, data_k is stable.
- Non-destination channels: are never written and drain independently in the same cycle.
- Round-robin pointer:
  - Increments mod 4 (3 -> 0 wrap) only on an accepted transfer while rr_mode=1.
  - Holds otherwise, including while rr_mode=0.
  - Changing rr_mode does not reset rr_ptr. The new mode governs dest in the same cycle it is applied (combinational).
- Round-robin stall: in rr_mode, if channel rr_ptr is full and not draining, x_ready=0 and the pointer waits. No channel is skipped.
- Input protocol: the upstream must hold x, s1, s0 stable while x_valid=1 and x_ready=0. The block does not latch the select before acceptance.
- idle = !(a_valid|b_valid|c_valid|d_valid), registered-valid derived.
- Ready without valid: ready_k asserted while valid_k=0 has no effect.
- Concurrency: all four channels may be valid simultaneously.
- Throughput: one word per cycle sustained when the destination consumer keeps its ready high.

Test Plan:
- Reset/idle:
  - Assert rst_n=0 mid-cycle with b_valid=1 -> all valids drop immediately, A..D=0, rr_ptr=0, idle=1.
- Select-driven steering:
  - rr_mode=0; send x=0x3 with {s1,s0}=2 and c_ready=1 -> next cycle C=0x3, c_valid=1, others 0.
  - Then c_valid clears the following cycle.
- Backpressure/hold:
  - Load A=0x5 with a_ready=0; present x=0x9 to dest 0 -> x_ready=0, A stays 0x5.
  - Present x=0x9 to dest 1 instead -> accepted, B=0x9 next cycle.
- Same-cycle drain+load:
  - a_valid=1 (A=0x5), a_ready=1, x=0xA to dest 0 -> x_ready=1.
  - Next cycle A=0xA, a_valid stays 1.
- Round-robin wrap:
  - rr_mode=1, all readies=1; send 0x1,0x2,0x3,0x4,0x5 back-to-back -> they land on A,B,C,D,A.
  - rr_ptr sequence 0,1,2,3,0,1.
- Round-robin stall:
  - rr_mode=1, rr_ptr=2, c_valid=1, c_ready=0 -> x_ready=0, rr_ptr holds 2.
  - Raise c_ready -> word accepted into C, rr_ptr=3.
